// File: rtl/fir_stream_out.sv
// Purpose : FIR output datapath - MAC over tap/data pairs, small output FIFO, AXI-Stream master.
// Latency : commit at edge N is visible on sm_tvalid/sm_tdata in cycle N+1; one beat per cycle.
// Backpressure: sm_tready stalls the FIFO; out_full stops the sequencer; a commit into a full
//               FIFO without a same-cycle pop is dropped and flags err_ovf.
//
// Build option: define FIR_OUT_SAT_EN to saturate accumulation/commit to the signed
// pDATA_WIDTH range instead of wrapping. Ports are identical in both builds.
//
// Ports:
//   axis_clk, axis_rst_n       clock, asynchronous active-low reset
//   x_in, h_in                 signed data sample / coefficient
//   mac_rst, mac_valid         clear accumulator / accumulate x_in*h_in
//   mac_tail, mac_last         commit current sample / committed sample ends the stream
//   out_full                   FIFO full (registered)
//   sm_tvalid/tdata/tlast      AXI-Stream master outputs, sm_tready input
//   stream_done                one-cycle pulse after the tlast beat is accepted
//   err_ovf                    sticky dropped-commit flag
module fir_stream_out #(
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic [pDATA_WIDTH-1:0] x_in,
  input  logic [pDATA_WIDTH-1:0] h_in,
  input  logic                   mac_rst,
  input  logic                   mac_valid,
  input  logic                   mac_tail,
  input  logic                   mac_last,
  output logic                   out_full,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   stream_done,
  output logic                   err_ovf
);

  localparam int LP_AW = $clog2(pFIFO_DEPTH);
  localparam int LP_CW = LP_AW + 1;
  localparam logic [LP_CW-1:0] LP_DEPTH = LP_CW'(pFIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------------
  logic [pDATA_WIDTH-1:0] r_acc;
  logic [pDATA_WIDTH-1:0] w_res;   // value stored to acc or committed this cycle

`ifdef FIR_OUT_SAT_EN
  localparam int LP_W2 = 2 * pDATA_WIDTH;
  localparam logic [LP_W2-1:0] LP_SMAX = {{(pDATA_WIDTH+1){1'b0}}, {(pDATA_WIDTH-1){1'b1}}};
  localparam logic [LP_W2-1:0] LP_SMIN = ~LP_SMAX;

  logic [LP_W2-1:0] w_x_ext;
  logic [LP_W2-1:0] w_h_ext;
  logic [LP_W2-1:0] w_prod;
  logic [LP_W2-1:0] w_term;
  logic [LP_W2-1:0] w_base;
  logic [LP_W2-1:0] w_sum;

  // Sign-extend first so the low 2W bits of the multiply are the full signed product.
  assign w_x_ext = {{pDATA_WIDTH{x_in[pDATA_WIDTH-1]}}, x_in};
  assign w_h_ext = {{pDATA_WIDTH{h_in[pDATA_WIDTH-1]}}, h_in};
  assign w_prod  = w_x_ext * w_h_ext;
  assign w_term  = mac_valid ? w_prod : '0;
  // mac_rst restarts from zero, so the same adder serves rst, tail and plain accumulate.
  assign w_base  = mac_rst ? '0 : {{pDATA_WIDTH{r_acc[pDATA_WIDTH-1]}}, r_acc};
  assign w_sum   = w_base + w_term;

  always_comb begin
    w_res = w_sum[pDATA_WIDTH-1:0];
    if ($signed(w_sum) > $signed(LP_SMAX)) begin
      w_res = LP_SMAX[pDATA_WIDTH-1:0];
    end else if ($signed(w_sum) < $signed(LP_SMIN)) begin
      w_res = LP_SMIN[pDATA_WIDTH-1:0];
    end
  end
`else
  logic [pDATA_WIDTH-1:0] w_prod_lo;
  logic [pDATA_WIDTH-1:0] w_term;
  logic [pDATA_WIDTH-1:0] w_base;

  // Only the low W bits survive wrapping, and those are the same for signed and
  // unsigned multiplication, so the narrow product is exact here.
  assign w_prod_lo = x_in * h_in;
  assign w_term    = mac_valid ? w_prod_lo : '0;
  assign w_base    = mac_rst ? '0 : r_acc;
  assign w_res     = w_base + w_term;
`endif

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_acc <= '0;
    end else if (mac_tail) begin
      r_acc <= '0;
    end else if (mac_rst || mac_valid) begin
      r_acc <= w_res;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [pDATA_WIDTH-1:0] r_mem_dat [pFIFO_DEPTH];
  logic                   r_mem_last[pFIFO_DEPTH];
  logic [LP_AW-1:0]       r_wr_ptr;
  logic [LP_AW-1:0]       r_rd_ptr;
  logic [LP_CW-1:0]       r_count;
  logic [LP_CW-1:0]       w_count_nxt;
  logic                   r_out_full;
  logic                   r_err_ovf;
  logic                   w_not_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == LP_DEPTH);
  assign w_pop       = w_not_empty && sm_tready;
  // A pop in the same cycle frees the slot the commit needs, even when full.
  assign w_push      = mac_tail && (!w_full || w_pop);
  assign w_drop      = mac_tail && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + LP_CW'(1);
      2'b01:   w_count_nxt = r_count - LP_CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is not reset: entries are only observable when counted as valid.
  always_ff @(posedge axis_clk) begin
    if (w_push) begin
      r_mem_dat[r_wr_ptr]  <= w_res;
      r_mem_last[r_wr_ptr] <= mac_last;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_full <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_AW'(1);
      end
      r_count    <= w_count_nxt;
      // Registered from the next count so it matches the current count each cycle.
      r_out_full <= (w_count_nxt == LP_DEPTH);
      if (w_drop) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

  assign out_full  = r_out_full;
  assign err_ovf   = r_err_ovf;
  assign sm_tvalid = w_not_empty;
  assign sm_tdata  = w_not_empty ? r_mem_dat[r_rd_ptr] : '0;
  assign sm_tlast  = w_not_empty ? r_mem_last[r_rd_ptr] : 1'b0;

  // ---------------------------------------------------------------------------
  // Stream FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_last_acc;
  logic   w_stream_done;

  assign w_last_acc = w_pop && r_mem_last[r_rd_ptr];

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A tlast beat can be accepted in the very cycle the FIFO first goes non-empty
  // (still IDLE) or right after another stream ended (DONE), so every state watches it.
  always_comb begin
    w_state_nxt   = r_state;
    w_stream_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_last_acc) begin
          w_state_nxt = S_DONE;
        end else if (w_not_empty) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_last_acc) begin
          w_state_nxt = S_DONE;
        end else if (w_count_nxt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_stream_done = 1'b1;
        if (w_last_acc) begin
          w_state_nxt = S_DONE;
        end else if (w_not_empty) begin
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign stream_done = w_stream_done;

endmodule
